// File: rtl/jt12_timer_ctl.sv
// jt12 timer register front end: decodes CPU port writes,
// drives the timer pair controls and returns the status byte.
module jt12_timer_ctl #(
  parameter int BUSY_CYCLES = 32,
  parameter int BUSY_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic [7:0] dout,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       fast_timers,
  output logic [1:0] ch3_mode,
  output logic       busy
);

  logic              strb;
  logic              strb_q;
  logic              wr_ev;
  logic              data_ev;
  logic              reg_ev;
  logic [7:0]        sel_reg;
  logic              sel_part;
  logic              run_A;
  logic              run_B;
  logic              start_A;
  logic              start_B;
  logic [BUSY_W-1:0] cnt;

  assign strb    = ~cs_n & ~wr_n;
  assign wr_ev   = strb & ~strb_q;
  assign data_ev = wr_ev & addr[0];
  assign reg_ev  = data_ev & ~sel_part & ~addr[1];

  // Strobe history follows the pins even in reset, so a
  // strobe held across reset release never fires an event.
  always_ff @(posedge clk) begin
    strb_q <= strb;
  end

  // Address port: register select and part latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg  <= 8'h00;
      sel_part <= 1'b0;
    end else if (wr_ev && !addr[0]) begin
      sel_reg  <= din;
      sel_part <= addr[1];
    end
  end

  // Part I timer/mode registers plus one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_A      <= 10'd0;
      value_B      <= 8'd0;
      run_A        <= 1'b0;
      run_B        <= 1'b0;
      start_A      <= 1'b0;
      start_B      <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      fast_timers  <= 1'b0;
      ch3_mode     <= 2'd0;
    end else begin
      start_A    <= 1'b0;
      start_B    <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (reg_ev) begin
        unique case (1'b1)
          sel_reg == 8'h21: fast_timers <= din[2];
          sel_reg == 8'h24: value_A[9:2] <= din;
          sel_reg == 8'h25: value_A[1:0] <= din[1:0];
          sel_reg == 8'h26: value_B <= din;
          sel_reg == 8'h27: begin
            run_A        <= din[0];
            run_B        <= din[1];
            start_A      <= din[0] & ~run_A;
            start_B      <= din[1] & ~run_B;
            enable_irq_A <= din[2];
            enable_irq_B <= din[3];
            clr_flag_A   <= din[4];
            clr_flag_B   <= din[5];
            ch3_mode     <= din[7:6];
          end
          default: ;
        endcase
      end
    end
  end

  // Busy counter: reloaded by any data write, counts down on cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (data_ev) begin
      cnt <= BUSY_W'(BUSY_CYCLES);
    end else if (cen && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy   = cnt != '0;
  assign load_A = ~run_A | start_A;
  assign load_B = ~run_B | start_B;
  assign dout   = {busy, 5'b0, flag_B, flag_A};

endmodule
